// File: rtl/power_arb_pkg.sv
// power_arb_pkg: default widths, width helpers and the
// round-robin priority select shared by the power arbiter.
package power_arb_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_RES_WIDTH    = 64;
    localparam int DEF_MAX_INFLIGHT = 8;

    // Widest requester set the select helper handles.
    localparam int RR_MAX   = 8;
    localparam int RR_IDX_W = 3;

    typedef struct packed {
        logic                found;
        logic [RR_MAX-1:0]   grant;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // First asserted valid at or above ptr, wrapping modulo n.
    function automatic rr_pick_t rr_select(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        rr_pick_t            pick;
        int                  pos;
        logic [RR_IDX_W-1:0] idx;
        pick = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            pos = int'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            idx = RR_IDX_W'(pos);
            if (k < n && !pick.found && valid[idx]) begin
                pick.found      = 1'b1;
                pick.grant[idx] = 1'b1;
                pick.idx        = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/power_tag_fifo.sv
// power_tag_fifo: in-order requester-ID FIFO for issued ops.
// Ports: push/push_data, pop/head, empty, full, count.
module power_tag_fifo
    import power_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_INFLIGHT,
    parameter int WIDTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra MSB on each pointer tells full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = CW'(wr_ptr - rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/power_req_arbiter.sv
// power_req_arbiter: round-robin share of one power unit.
// Ports: req_* in, pw_* to/from power, rsp_* out, credits.
module power_req_arbiter
    import power_arb_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RES_WIDTH    = DEF_RES_WIDTH,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int ID_WIDTH     = id_width(N_REQ),
    localparam int CNT_WIDTH   = cnt_width(MAX_INFLIGHT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        pw_i_valid,
    output logic [DATA_WIDTH-1:0]       pw_i_data,
    input  logic                        pw_o_valid,
    input  logic [RES_WIDTH-1:0]        pw_o_data,
    output logic                        rsp_valid,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [RES_WIDTH-1:0]        rsp_data,
    output logic [CNT_WIDTH-1:0]        inflight,
    output logic                        err_orphan
);

    rr_pick_t              pick;
    logic                  unused_pick;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  xfer;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ID_WIDTH-1:0]   fifo_head;

    assign pick = rr_select(RR_MAX'(req_valid),
                            RR_IDX_W'(rr_ptr), N_REQ);
    assign unused_pick = ^pick;

    assign win_id   = pick.idx[ID_WIDTH-1:0];
    assign win_data = req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr = (int'(win_id) == N_REQ - 1) ?
                      '0 : win_id + 1'b1;

    // FIFO occupancy is the credit count; a full FIFO
    // means MAX_INFLIGHT ops are outstanding.
    assign req_ready = (!reset && !fifo_full) ?
                       pick.grant[N_REQ-1:0] : '0;
    assign xfer = |(req_valid & req_ready);
    assign pop  = pw_o_valid && !fifo_empty;

    power_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ID_WIDTH)
    ) u_tags (
        .clk       (clk),
        .reset     (reset),
        .push      (xfer),
        .push_data (win_id),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (inflight)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            pw_i_valid <= 1'b0;
            pw_i_data  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            pw_i_valid <= xfer;
            pw_i_data  <= xfer ? win_data : '0;
            if (xfer) begin
                rr_ptr <= next_ptr;
            end
            rsp_valid <= pop;
            if (pop) begin
                rsp_id   <= fifo_head;
                rsp_data <= pw_o_data;
            end
            // A result with no owner is sticky until reset.
            if (pw_o_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule
